lab3nios_cpu_mul_combine: RTL and testbench
===========================================

// Module: lab3nios_cpu_mul_combine
// PURPOSE
//  Consumer end of the CPU multiplier cell: takes the three registered 16x16 partial products
//  (p1=a_lo*b_lo, p2=a_lo*b_hi, p3=a_hi*b_lo) plus the original operands.
//  Assembles the 32-bit MUL result, or with MULX support the upper word of the 64-bit product.
//  Sits between the mult cell outputs (M stage) and the writeback mux.
//  Uses a valid/ready handshake on both sides.
// PARAMETERS
//  DATA_W    32  operand/result width; only 32 is supported
//  HALF_W    16  partial-multiplier operand width (DATA_W/2)
// PORTS
//  clk        in   1   system clock
//  reset_n    in   1   synchronous active-low reset
//  in_valid   in   1   partial products + operands valid
//  in_ready   out  1   block can accept (state IDLE and reset_n high)
//  op         in   2   00 MUL, 01 MULXUU, 10 MULXSU (src1 signed), 11 MULXSS
//  src1       in   32  original operand a
//  src2       in   32  original operand b
//  p1         in   32  a[15:0]*b[15:0], unsigned
//  p2         in   32  a[15:0]*b[31:16], unsigned
//  p3         in   32  a[31:16]*b[15:0], unsigned
//  out_valid  out  1   result valid; held until accepted
//  out_ready  in   1   downstream accepts result
//  result     out  32  low word (MUL) or high word (MULX*)
// BEHAVIOUR
//  - Reset (reset_n low at a clk edge, any state): state=IDLE, out_valid=0, result=0,
//    internal accumulators=0. in_ready=0 while reset_n is low.
//  - Accept: in_valid & in_ready at an edge; op/src/p* are captured; no input held afterwards.
//  - Low word: lo = p1 + ((p2 + p3) << 16), modulo 2^32.
//  - MUL: IDLE -> DONE. out_valid=1, result=lo one cycle after accept.
//  - MULX: IDLE -> HH -> MID -> FIX -> DONE. out_valid 4 cycles after accept.
//    - HH: hh = src1[31:16]*src2[31:16], unsigned, 32 bits, from an internal 16x16 multiply.
//    - MID: acc64 = {hh,32'b0} + {15'b0,(p2+p3),16'b0} + p1. Keep all 33 bits of p2+p3.
//    - FIX: if op signs src1 and src1[31]=1, subtract {src2,32'b0}.
//      If op=11 and src2[31]=1, subtract {src1,32'b0}. Both subtractions are mod 2^64.
//    - DONE: result = acc64[63:32].
//  - DONE: result/out_valid stable until out_ready=1; then IDLE on the next edge.
//    No accept in the same cycle as the drain; max throughput is 1 MUL per 2 cycles.
//  - in_ready=0 in HH/MID/FIX/DONE. in_valid is ignored there; no capture, no error.
//  - out_ready while out_valid=0 has no effect.
//  - Reset in any state aborts the operation; the partial result is discarded and never presented.
// CONFIGURATION
//  - LAB3NIOS_MUL_MULX_EN defined: full MULX path as above (HH/MID/FIX states, hh multiplier).
//  - Not defined: op is ignored and every op behaves as MUL (1-cycle latency).
//    FSM reduces to IDLE/DONE; no hh multiplier or 64-bit accumulator is built.
// TESTING
//  1. MUL src1=0x00010003 src2=0x00020005 p1=0xF p2=0x6 p3=0x5
//     -> result=0x000B000F, out_valid 1 cycle after accept.
//  2. [EN] MULXUU 0xFFFFFFFF*0xFFFFFFFF (p1=p2=p3=0xFFFE0001)
//     -> result=0xFFFFFFFE, out_valid exactly 4 cycles after accept.
//  3. [EN] MULXSS 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000.
//     MULXSU same operands -> 0xFFFFFFFF.
//     MULXSS 0x80000000*0x80000000 -> 0x40000000.
//  4. Hold out_ready=0 for 5 cycles after out_valid while pulsing in_valid
//     -> result stable, in_ready=0, no new capture. Release -> IDLE, in_ready=1 next cycle.
//  5. [EN] Assert reset_n=0 for 1 cycle while in FIX
//     -> next cycle IDLE, out_valid=0, result=0. A following MUL completes correctly.
//  6. [no EN] op=11 src1=0x00010003 src2=0x00020005 -> result=0x000B000F after 1 cycle.

Source files
------------

// File: rtl/lab3nios_cpu_mul_combine_if.sv
// rtl/lab3nios_cpu_mul_combine_if.sv - handshake bundle between mult cell, combiner and writeback
interface lab3nios_cpu_mul_combine_if #(parameter int DATA_W = 32);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        op;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [DATA_W-1:0] p1;
    logic [DATA_W-1:0] p2;
    logic [DATA_W-1:0] p3;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;

    modport master (
        output in_valid, op, src1, src2, p1, p2, p3, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, src1, src2, p1, p2, p3, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/lab3nios_cpu_mul_combine.sv
// rtl/lab3nios_cpu_mul_combine.sv - combines 16x16 partial products into MUL / MULX results
// Optional MULX upper-word path is built when LAB3NIOS_MUL_MULX_EN is defined.
module lab3nios_cpu_mul_combine #(
    parameter int DATA_W = 32,
    parameter int HALF_W = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    lab3nios_cpu_mul_combine_if.slave     bus
);

`ifdef LAB3NIOS_MUL_MULX_EN
    typedef enum logic [2:0] {S_IDLE, S_HH, S_MID, S_FIX, S_DONE} state_t;
`else
    typedef enum logic [0:0] {S_IDLE, S_DONE} state_t;
`endif

    state_t            state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [HALF_W-1:0] mid_lo;
    logic [DATA_W-1:0] lo;

    // Only the low half of p2+p3 survives the shift into a 32-bit word.
    assign mid_lo = bus.p2[HALF_W-1:0] + bus.p3[HALF_W-1:0];
    assign lo     = bus.p1 + {mid_lo, {HALF_W{1'b0}}};

    assign bus.in_ready  = (state_q == S_IDLE) && reset_n;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;

`ifdef LAB3NIOS_MUL_MULX_EN
    logic [1:0]          op_q, op_d;
    logic [DATA_W-1:0]   src1_q, src1_d, src2_q, src2_d;
    logic [DATA_W-1:0]   p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
    logic [DATA_W-1:0]   hh_q, hh_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W:0]     mid_sum;
    logic [2*DATA_W-1:0] acc_mid, acc_fix;

    assign mid_sum = {1'b0, p2_q} + {1'b0, p3_q};
    assign acc_mid = {hh_q, {DATA_W{1'b0}}}
                   + {{(HALF_W-1){1'b0}}, mid_sum, {HALF_W{1'b0}}}
                   + {{DATA_W{1'b0}}, p1_q};
    // Signed corrections: a negative operand contributes -2^32 times the other operand.
    assign acc_fix = acc_q
                   - ((op_q[1] && src1_q[DATA_W-1]) ? {src2_q, {DATA_W{1'b0}}} : '0)
                   - ((op_q == 2'b11 && src2_q[DATA_W-1]) ? {src1_q, {DATA_W{1'b0}}} : '0);
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
`ifdef LAB3NIOS_MUL_MULX_EN
        op_d   = op_q;
        src1_d = src1_q;
        src2_d = src2_q;
        p1_d   = p1_q;
        p2_d   = p2_q;
        p3_d   = p3_q;
        hh_d   = hh_q;
        acc_d  = acc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
`ifdef LAB3NIOS_MUL_MULX_EN
                    if (bus.op == 2'b00) begin
                        result_d = lo;
                        state_d  = S_DONE;
                    end else begin
                        op_d    = bus.op;
                        src1_d  = bus.src1;
                        src2_d  = bus.src2;
                        p1_d    = bus.p1;
                        p2_d    = bus.p2;
                        p3_d    = bus.p3;
                        state_d = S_HH;
                    end
`else
                    result_d = lo;
                    state_d  = S_DONE;
`endif
                end
            end
`ifdef LAB3NIOS_MUL_MULX_EN
            S_HH: begin
                hh_d    = {{HALF_W{1'b0}}, src1_q[DATA_W-1:HALF_W]}
                        * {{HALF_W{1'b0}}, src2_q[DATA_W-1:HALF_W]};
                state_d = S_MID;
            end
            S_MID: begin
                acc_d   = acc_mid;
                state_d = S_FIX;
            end
            S_FIX: begin
                acc_d    = acc_fix;
                result_d = acc_fix[2*DATA_W-1:DATA_W];
                state_d  = S_DONE;
            end
`endif
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
`ifdef LAB3NIOS_MUL_MULX_EN
            op_q   <= '0;
            src1_q <= '0;
            src2_q <= '0;
            p1_q   <= '0;
            p2_q   <= '0;
            p3_q   <= '0;
            hh_q   <= '0;
            acc_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
`ifdef LAB3NIOS_MUL_MULX_EN
            op_q   <= op_d;
            src1_q <= src1_d;
            src2_q <= src2_d;
            p1_q   <= p1_d;
            p2_q   <= p2_d;
            p3_q   <= p3_d;
            hh_q   <= hh_d;
            acc_q  <= acc_d;
`endif
        end
    end

endmodule

// File: tb/tb_lab3nios_cpu_mul_combine.sv
// tb/tb_lab3nios_cpu_mul_combine.sv - self-checking bench for lab3nios_cpu_mul_combine
module tb_lab3nios_cpu_mul_combine;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    lab3nios_cpu_mul_combine_if bus ();

    lab3nios_cpu_mul_combine dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: full-width product, sign handling by operand extension.
    function automatic logic [31:0] mdl_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, prod;
`ifdef LAB3NIOS_MUL_MULX_EN
        ea   = op[1] ? {{32{a[31]}}, a} : {32'b0, a};
        eb   = (op == 2'b11) ? {{32{b[31]}}, b} : {32'b0, b};
        prod = ea * eb;
        return (op == 2'b00) ? prod[31:0] : prod[63:32];
`else
        ea   = {32'b0, a};
        eb   = {32'b0, b};
        prod = ea * eb;
        return prod[31:0];
`endif
    endfunction

    function automatic int mdl_latency(input logic [1:0] op);
`ifdef LAB3NIOS_MUL_MULX_EN
        return (op == 2'b00) ? 1 : 4;
`else
        return 1;
`endif
    endfunction

    bit          m_busy = 1'b0;
    int          m_cnt  = 0;
    logic [31:0] m_res  = '0;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_busy = 1'b0;
            m_cnt  = 0;
            m_res  = '0;
        end else if (m_busy) begin
            if (m_cnt != 0) m_cnt--;
            else if (bus.out_ready) m_busy = 1'b0;
        end else if (bus.in_valid) begin
            m_busy = 1'b1;
            m_cnt  = mdl_latency(bus.op) - 1;
            m_res  = mdl_result(bus.op, bus.src1, bus.src2);
        end
    end

    always @(negedge clk) begin
        #2;
        if (started) begin
            check("cyc_in_ready", {31'b0, bus.in_ready}, {31'b0, reset_n && !m_busy});
            check("cyc_out_valid", {31'b0, bus.out_valid}, {31'b0, m_busy && (m_cnt == 0)});
            if (m_busy && m_cnt == 0) check("cyc_result", bus.result, m_res);
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        bus.op       = o;
        bus.src1     = a;
        bus.src2     = b;
        bus.p1       = {16'b0, a[15:0]} * {16'b0, b[15:0]};
        bus.p2       = {16'b0, a[15:0]} * {16'b0, b[31:16]};
        bus.p3       = {16'b0, a[31:16]} * {16'b0, b[15:0]};
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run(input string name, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        issue(o, a, b);
        wait_valid(lat);
        check({name, "_result"}, bus.result, exp);
        check({name, "_latency"}, lat, exp_lat);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] r0;
        int lat;
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.src1      = '0;
        bus.src2      = '0;
        bus.p1        = '0;
        bus.p2        = '0;
        bus.p3        = '0;
        bus.out_ready = 1'b1;
        reset_n       = 1'b0;
        @(posedge clk);
        started = 1'b1;
        @(negedge clk);
        check("reset_result", bus.result, 32'h0);
        check("reset_out_valid", {31'b0, bus.out_valid}, 32'h0);
        check("reset_in_ready", {31'b0, bus.in_ready}, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        check("model_mul", mdl_result(2'b00, 32'h00010003, 32'h00020005), 32'h000B000F);
        run("t1_mul", 2'b00, 32'h00010003, 32'h00020005, 32'h000B000F, 1);
        run("mul_a", 2'b00, 32'hDEADBEEF, 32'h12345678, mdl_result(2'b00, 32'hDEADBEEF, 32'h12345678), 1);
        run("mul_zero", 2'b00, 32'h0, 32'hFFFFFFFF, 32'h0, 1);

`ifdef LAB3NIOS_MUL_MULX_EN
        check("model_xss", mdl_result(2'b11, 32'h80000000, 32'h80000000), 32'h40000000);
        run("t2_xuu", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4);
        run("t3_xss", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4);
        run("t3_xsu", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4);
        run("t3_xss_min", 2'b11, 32'h80000000, 32'h80000000, 32'h40000000, 4);
        run("xuu_b", 2'b01, 32'h12345678, 32'h9ABCDEF0, mdl_result(2'b01, 32'h12345678, 32'h9ABCDEF0), 4);
        run("xsu_b", 2'b10, 32'h9ABCDEF0, 32'h0000FFFF, mdl_result(2'b10, 32'h9ABCDEF0, 32'h0000FFFF), 4);
        run("xss_b", 2'b11, 32'h7FFFFFFF, 32'h80000001, mdl_result(2'b11, 32'h7FFFFFFF, 32'h80000001), 4);
`else
        run("t6_op11", 2'b11, 32'h00010003, 32'h00020005, 32'h000B000F, 1);
        run("op01", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1);
        run("op10", 2'b10, 32'h80000000, 32'h80000000, 32'h00000000, 1);
`endif

        bus.out_ready = 1'b0;
        issue(2'b00, 32'h00010003, 32'h00020005);
        wait_valid(lat);
        check("t4_latency", lat, 1);
        r0 = bus.result;
        check("t4_first", r0, 32'h000B000F);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = ~bus.in_valid;
            bus.src1     = $urandom;
            bus.p1       = $urandom;
            @(negedge clk);
            check("t4_stable", bus.result, 32'h000B000F);
            check("t4_in_ready", {31'b0, bus.in_ready}, 32'h0);
            check("t4_out_valid", {31'b0, bus.out_valid}, 32'h1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("t4_release_in_ready", {31'b0, bus.in_ready}, 32'h1);
        check("t4_release_out_valid", {31'b0, bus.out_valid}, 32'h0);

`ifdef LAB3NIOS_MUL_MULX_EN
        issue(2'b11, 32'h80000000, 32'h80000000);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("t5_out_valid", {31'b0, bus.out_valid}, 32'h0);
        check("t5_result", bus.result, 32'h0);
        reset_n = 1'b1;
        #1;
        check("t5_in_ready", {31'b0, bus.in_ready}, 32'h1);
        @(negedge clk);
        run("t5_after", 2'b00, 32'h00010003, 32'h00020005, 32'h000B000F, 1);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end
endmodule
